// File: rtl/alu_driver_if.sv
// Bus bundle for alu_driver: command handshake, registered ALU drive, response handshake.
// slave = the driver block, master = the sequencer/ALU side that surrounds it.
interface alu_driver_if #(
    parameter int W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   cmd_s;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_s;
    logic [W-1:0] alu_y;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic [3:0]   rsp_s;
    logic         rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_s,
        input  cmd_ready,
        input  alu_a, alu_b, alu_s,
        output alu_y,
        input  rsp_valid, rsp_y, rsp_s, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_s,
        output cmd_ready,
        output alu_a, alu_b, alu_s,
        input  alu_y,
        output rsp_valid, rsp_y, rsp_s, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_driver.sv
// Command FIFO + IDLE/DRIVE/RESP sequencer in front of an external combinational ALU.
// Optional feature macro: ALU_DRIVER_DIVZERO_EN (flag divide/modulo by zero on rsp_err).
module alu_driver #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_driver_if.slave bus,
    output logic [1:0]  fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * W + 4;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic          release_rsp;

    logic [W-1:0]  alu_a_q;
    logic [W-1:0]  alu_b_q;
    logic [3:0]    alu_s_q;
    logic          rsp_valid_q;
    logic [W-1:0]  rsp_y_q;
    logic [3:0]    rsp_s_q;
    logic [W-1:0]  y_next;

    // Both handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; the producer holds valid and payload stable until that edge.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = bus.cmd_valid && bus.cmd_ready;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign bus.cmd_ready = !full && !rst;

    // Storage carries no reset; a reset simply abandons its contents via the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.cmd_a, bus.cmd_b, bus.cmd_s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = empty ? IDLE : DRIVE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RESP always has rsp_valid set, so rsp_ready alone marks the response handshake there.
    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
            end
            DRIVE: begin
                capture = 1'b1;
            end
            RESP: begin
                release_rsp = bus.rsp_ready;
                pop         = bus.rsp_ready && !empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_s_q <= '0;
        end else if (pop) begin
            {alu_a_q, alu_b_q, alu_s_q} <= head;
        end
    end

`ifdef ALU_DRIVER_DIVZERO_EN
    logic div_zero;
    logic rsp_err_q;

    assign div_zero = ((alu_s_q == 4'b0011) || (alu_s_q == 4'b0100)) && (alu_b_q == '0);
    assign y_next   = div_zero ? '0 : bus.alu_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (capture) begin
            rsp_err_q <= div_zero;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign y_next      = bus.alu_y;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_s_q     <= '0;
        end else if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= y_next;
            rsp_s_q     <= alu_s_q;
        end else if (release_rsp) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_s     = rsp_s_q;
    assign fsm_state     = state;
endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: vector table for single commands, scoreboard for streams,
// plus hand-written back-to-back, capacity/wrap and mid-operation reset sequences.
module tb_alu_driver;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic [W-1:0] y;
    logic         err;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  int         checks;
  int         errors;
  int         cyc;
  bit         sb_on;
  bit         gap_on;
  int         last_hs;
  logic [W+3:0] exp_q[$];
  vec_t       vecs[8];

  alu_driver_if #(.W(W)) bus ();

  alu_driver #(.W(W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // External ALU stand-in; opcode 13 adds, divide/modulo by zero give fixed junk values.
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == '0) ? '1 : a / b;
      4'd4:    return (b == '0) ? a : a % b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd13:   return a + b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb bus.alu_y = alu_model(bus.alu_a, bus.alu_b, bus.alu_s);

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard: compares each response at the negedge before its handshake edge
  initial begin
    logic [W+3:0] e;
    forever begin
      @(negedge clk);
      if (sb_on && !rst && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", {bus.rsp_s, bus.rsp_y}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_rsp", {bus.rsp_s, bus.rsp_y}, e);
          if (gap_on && last_hs >= 0) check("sb_gap", cyc - last_hs, 2);
          last_hs = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_s = s;
    bus.cmd_valid = 1'b1;
    check("push_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic fill(input logic [3:0] s, input int base, input int bval, output int accepted);
    accepted = 0;
    for (int k = 0; k < 10; k++) begin
      bus.cmd_a = 4'(base + accepted);
      bus.cmd_b = 4'(bval);
      bus.cmd_s = s;
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready) begin
        exp_q.push_back({s, alu_model(4'(base + accepted), 4'(bval), s)});
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int acc;
    logic [W-1:0] b2b_y[4];
    checks = 0;
    errors = 0;
    sb_on = 1'b0;
    gap_on = 1'b0;
    last_hs = -1;

    vecs[0] = '{a: 4'd12, b: 4'd2, s: 4'd0,  y: 4'd14, err: 1'b0};
    vecs[1] = '{a: 4'd12, b: 4'd2, s: 4'd1,  y: 4'd10, err: 1'b0};
    vecs[2] = '{a: 4'd12, b: 4'd2, s: 4'd2,  y: 4'd8,  err: 1'b0};
    vecs[3] = '{a: 4'd12, b: 4'd2, s: 4'd4,  y: 4'd0,  err: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd1, s: 4'd0,  y: 4'd0,  err: 1'b0};
    vecs[5] = '{a: 4'd3,  b: 4'd1, s: 4'd13, y: 4'd4,  err: 1'b0};
`ifdef ALU_DRIVER_DIVZERO_EN
    vecs[6] = '{a: 4'd12, b: 4'd0, s: 4'd3,  y: 4'd0,  err: 1'b1};
    vecs[7] = '{a: 4'd12, b: 4'd0, s: 4'd4,  y: 4'd0,  err: 1'b1};
`else
    vecs[6] = '{a: 4'd12, b: 4'd0, s: 4'd3,  y: 4'd15, err: 1'b0};
    vecs[7] = '{a: 4'd12, b: 4'd0, s: 4'd4,  y: 4'd12, err: 1'b0};
`endif
    b2b_y = '{4'd10, 4'd8, 4'd6, 4'd0};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_s = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    check("rst_rsp_s", bus.rsp_s, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_s", bus.alu_s, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // single commands: latency, registered drive, capture, release
    bus.rsp_ready = 1'b1;
    foreach (vecs[i]) begin
      push(vecs[i].a, vecs[i].b, vecs[i].s);
      check($sformatf("v%0d_valid_n0", i), bus.rsp_valid, 0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].a);
      check($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].b);
      check($sformatf("v%0d_alu_s", i), bus.alu_s, vecs[i].s);
      check($sformatf("v%0d_state_drive", i), fsm_state, 1);
      check($sformatf("v%0d_valid_n1", i), bus.rsp_valid, 0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid_n2", i), bus.rsp_valid, 1);
      check($sformatf("v%0d_rsp_y", i), bus.rsp_y, vecs[i].y);
      check($sformatf("v%0d_rsp_s", i), bus.rsp_s, vecs[i].s);
      check($sformatf("v%0d_rsp_err", i), bus.rsp_err, vecs[i].err);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid_released", i), bus.rsp_valid, 0);
      check($sformatf("v%0d_state_idle", i), fsm_state, 0);
    end

    // back-to-back stream: in order, one response every 2 cycles
    sb_on = 1'b1;
    gap_on = 1'b1;
    last_hs = -1;
    for (int s = 1; s <= 4; s++) begin
      exp_q.push_back({4'(s), b2b_y[s-1]});
      push(4'd12, 4'd2, 4'(s));
    end
    wait_drain(40);
    gap_on = 1'b0;

    // capacity with rsp_ready low, then drain; repeat to wrap the pointers
    for (int pass = 0; pass < 2; pass++) begin
      bus.rsp_ready = 1'b0;
      fill(pass == 0 ? 4'd0 : 4'd1, pass == 0 ? 1 : 8, pass == 0 ? 1 : 3, acc);
      check($sformatf("cap%0d_accepted", pass), acc, 5);
      check($sformatf("cap%0d_cmd_ready", pass), bus.cmd_ready, 0);
      check($sformatf("cap%0d_rsp_valid", pass), bus.rsp_valid, 1);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("cap%0d_held_y", pass), bus.rsp_y, pass == 0 ? 2 : 5);
      check($sformatf("cap%0d_held_s", pass), bus.rsp_s, pass == 0 ? 0 : 1);
      bus.rsp_ready = 1'b1;
      wait_drain(40);
      check($sformatf("cap%0d_ready_after", pass), bus.cmd_ready, 1);
    end

    // reset with 3 queued and one response held
    bus.rsp_ready = 1'b0;
    push(4'd3, 4'd3, 4'd1);
    push(4'd4, 4'd4, 4'd1);
    push(4'd5, 4'd5, 4'd1);
    push(4'd6, 4'd6, 4'd1);
    check("held_before_rst", bus.rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_alu_a", bus.alu_a, 0);
    check("midrst_alu_b", bus.alu_b, 0);
    check("midrst_alu_s", bus.alu_s, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 0);
    check("midrst_state", fsm_state, 0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("no_stale_%0d", k), bus.rsp_valid, 0);
    end
    exp_q.push_back({4'd13, 4'd4});
    push(4'd3, 4'd1, 4'd13);
    wait_drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_driver.md
# alu_driver

Sequential command front-end for the 4-bit combinational ALU (opcode `s`, operands `a`/`b`, result `y`). It accepts operation requests over a valid/ready handshake, buffers them in a small FIFO, drives the ALU's `a`/`b`/`s` inputs from registers, samples `y` after one settling cycle, and returns each result over a second valid/ready handshake. It sits between a controller or testbench sequencer and the combinational ALU, which is instantiated outside this block.

## Interface
- `W`, default 4: operand and result width; must match the ALU.
- `DEPTH`, default 4: command FIFO depth; must be a power of two, at least 2.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_a` in W: operand a.
- `cmd_b` in W: operand b.
- `cmd_s` in 4: ALU opcode.
- `alu_a` out W: registered, drives ALU `a`.
- `alu_b` out W: registered, drives ALU `b`.
- `alu_s` out 4: registered, drives ALU `s`.
- `alu_y` in W: ALU result `y`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_y` out W: captured result.
- `rsp_s` out 4: opcode that produced `rsp_y`.
- `rsp_err` out 1: divide or modulo by zero, when `ALU_DRIVER_DIVZERO_EN` is defined.

## Operation
- A push occurs when `cmd_valid && cmd_ready`. `cmd_ready = !full && !rst`.
- The FIFO stores `{a,b,s}`. Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full is when the MSBs differ and the low bits are equal. Empty is when the pointers are equal.
- The FSM has three states: IDLE, DRIVE, RESP.
  - IDLE: if the FIFO is not empty, pop the head into `alu_a/alu_b/alu_s`, then go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: lasts exactly one cycle while the ALU settles. At the closing edge, load `rsp_y ← alu_y` and `rsp_s ← alu_s`, set `rsp_valid = 1`, and go to RESP.
  - RESP: hold `rsp_*` stable until `rsp_valid && rsp_ready`. On that edge, clear `rsp_valid`. If the FIFO is not empty, pop the next command into `alu_*` and go to DRIVE. Otherwise go to IDLE.
- `alu_a/alu_b/alu_s` change only on a pop. They hold their last value otherwise.
- The block does not widen results. `rsp_y` is the ALU's W-bit result as presented; for example, 12·2 gives 8 when W=4.
- A push and a pop may occur on the same edge. The count is unchanged, and both pointers advance.
- A push is refused while the FIFO is full, even if a pop occurs on that edge. `cmd_ready` reflects the registered full state only.
- Reset mid-operation: every FIFO entry and any in-flight or held response is discarded. No response is emitted for them.

## Timing
- Reset values:
  - `cmd_ready = 0` while `rst` is high, then 1 from the first cycle after it is released.
  - `rsp_valid = 0`, `rsp_y = 0`, `rsp_s = 0`, `rsp_err = 0`.
  - `alu_a = 0`, `alu_b = 0`, `alu_s = 0`.
  - FSM in IDLE, pointers 0.
- Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. `rsp_valid` goes high after edge N+2, so latency is 2 cycles.
- Throughput with `rsp_ready` held high is one response every 2 cycles (RESP then DRIVE).
- Capacity with `rsp_ready` held low: one command is held in RESP plus DEPTH commands in the FIFO. `cmd_ready` falls after the (DEPTH+1)th accepted command.
- `rsp_*` stays stable from the rising of `rsp_valid` until the handshake edge.

## Configuration
- `ALU_DRIVER_DIVZERO_EN` defined:
  - In DRIVE, if `alu_s` is 4'b0011 (divide) or 4'b0100 (modulo) and `alu_b == 0`, then `rsp_err = 1` and `rsp_y = 0`, overriding `alu_y`.
  - Otherwise `rsp_err = 0`.
  - `rsp_err` is captured together with `rsp_y`.
- `ALU_DRIVER_DIVZERO_EN` undefined:
  - `rsp_err` is tied to 0.
  - `rsp_y` always equals the captured `alu_y`, including the ALU's undefined divide-by-zero result.

## Test plan
- Reset, then push a=12, b=2, s=0 with `rsp_ready=1`: `rsp_valid` rises 2 cycles after the push, with `rsp_y=14` and `rsp_s=0`.
- Push s=1, 2, 3, 4 back-to-back with a=12, b=2: responses arrive in order with values 10, 8, 6, 0, spaced 2 cycles apart.
- With the macro defined, push a=12, b=0, s=3: `rsp_err=1`, `rsp_y=0`. With the macro undefined: `rsp_err=0`.
- Hold `rsp_ready=0` and push continuously: exactly DEPTH+1 (5) commands are accepted and `cmd_ready` stays low. Then release `rsp_ready`: all 5 results drain in order, and pointers wrap correctly on a second fill of 5.
- Assert `rst` for one cycle while 3 commands are queued and a response is held: `rsp_valid` and the `alu_*` outputs are 0 on the following cycle. No stale response appears afterward, and a new push a=3, b=1, s=13 returns 4.
